// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and issue-bundle payload for the ALU issue stage.
package alu_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_NOR  = 4'b1100;
    localparam logic [OP_W-1:0] ALU_BLT  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_ADDI = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SLLI = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BLT     = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} issue_state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OP_W-1:0] alu_op;
        logic [4:0]      rd;
        logic            reg_write;
        logic            branch;
        logic            illegal;
    } issue_bundle_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV64I field decode into the ALU issue bundle.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output issue_bundle_t   o_bundle_c
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd;
    logic       w_legal;
    logic       w_unused_rs_fields;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_rd     = i_instr[11:7];
    // Register indices were consumed by the register file read upstream.
    assign w_unused_rs_fields = &{1'b0, i_instr[24:15]};

    always_comb begin
        o_bundle_c = '0;
        w_legal    = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                o_bundle_c.a         = i_rs1_data;
                o_bundle_c.b         = i_rs2_data;
                o_bundle_c.rd        = w_rd;
                o_bundle_c.reg_write = 1'b1;
                w_legal              = 1'b1;
                case ({w_f7, w_f3})
                    {F7_BASE, F3_ADD_SUB}: o_bundle_c.alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD_SUB}: o_bundle_c.alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}:     o_bundle_c.alu_op = ALU_AND;
                    {F7_BASE, F3_OR}:      o_bundle_c.alu_op = ALU_OR;
                    {F7_ALT,  F3_XOR}:     o_bundle_c.alu_op = ALU_NOR;
                    default:               w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                o_bundle_c.a         = i_rs1_data;
                o_bundle_c.rd        = w_rd;
                o_bundle_c.reg_write = 1'b1;
                if (w_f3 == F3_ADD_SUB) begin
                    o_bundle_c.alu_op = ALU_ADDI;
                    o_bundle_c.b      = sext12(i_instr[31:20]);
                    w_legal           = 1'b1;
                end else if (w_f3 == F3_SLL && i_instr[31:26] == 6'b0) begin
                    o_bundle_c.alu_op = ALU_SLLI;
                    o_bundle_c.b      = XLEN'(i_instr[25:20]);
                    w_legal           = 1'b1;
                end
            end
            OPC_BRANCH: begin
                o_bundle_c.a      = i_rs1_data;
                o_bundle_c.b      = i_rs2_data;
                o_bundle_c.branch = 1'b1;
                if (w_f3 == F3_BLT) begin
                    o_bundle_c.alu_op = ALU_BLT;
                    w_legal           = 1'b1;
                end else if (w_f3 == F3_BEQ) begin
                    o_bundle_c.alu_op = ALU_SUB;
                    w_legal           = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (w_f3 == F3_DWORD) begin
                    o_bundle_c.a         = i_rs1_data;
                    o_bundle_c.b         = sext12(i_instr[31:20]);
                    o_bundle_c.alu_op    = ALU_ADD;
                    o_bundle_c.rd        = w_rd;
                    o_bundle_c.reg_write = 1'b1;
                    w_legal              = 1'b1;
                end
            end
            OPC_STORE: begin
                if (w_f3 == F3_DWORD) begin
                    o_bundle_c.a      = i_rs1_data;
                    o_bundle_c.b      = sext12({i_instr[31:25], i_instr[11:7]});
                    o_bundle_c.alu_op = ALU_ADD;
                    w_legal           = 1'b1;
                end
            end
            default: ;
        endcase
        // Unsupported encodings still flow downstream, flagged and zeroed.
        if (!w_legal) begin
            o_bundle_c         = '0;
            o_bundle_c.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register with one-entry skid buffer feeding the 64-bit ALU.
// Optional ISSUE_PERF_EN adds issued/bubble performance counters.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [OP_W-1:0] ex_alu_op,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_illegal
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_bubble
`endif
);

    issue_state_e  r_state;
    issue_bundle_t r_out;
    issue_bundle_t r_skid;
    logic          r_ex_valid;
    logic          r_in_ready;
    issue_bundle_t w_dec;
    logic          w_accept;
    logic          w_out;

    alu_issue_decode u_decode (
        .i_instr    (instr),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_bundle_c (w_dec)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_out    = r_ex_valid & ex_ready;

    // Flush overrides both handshakes; data registers may keep stale contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_ex_valid <= 1'b0;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_ex_valid <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_out      <= w_dec;
                        r_ex_valid <= 1'b1;
                        r_state    <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_out) begin
                        r_out <= w_dec;
                    end else if (w_out) begin
                        r_ex_valid <= 1'b0;
                        r_state    <= EMPTY;
                    end else if (w_accept) begin
                        r_skid     <= w_dec;
                        r_in_ready <= 1'b0;
                        r_state    <= SKID;
                    end
                end
                SKID: begin
                    if (w_out) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= FULL;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_ex_valid <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign ex_valid     = r_ex_valid;
    assign ex_a         = r_out.a;
    assign ex_b         = r_out.b;
    assign ex_alu_op    = r_out.alu_op;
    assign ex_rd        = r_out.rd;
    assign ex_reg_write = r_out.reg_write;
    assign ex_branch    = r_out.branch;
    assign ex_illegal   = r_out.illegal;

`ifdef ISSUE_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_bubble;

    // Counters survive flush; a flushed output beat is not a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_issued <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_out && !flush) r_perf_issued <= r_perf_issued + 32'd1;
            if (ex_ready && !r_ex_valid) r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a scoreboard of expected ALU bundles.
module tb_alu_issue_stage;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_a;
    logic [63:0] ex_b;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_branch;
    logic        ex_illegal;
`ifdef ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_bubble;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_xfer = 0;
    int   n_bubble = 0;
    logic stall_prev = 1'b0;
    exp_t snap;

    alu_issue_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_alu_op    (ex_alu_op),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_branch    (ex_branch),
        .ex_illegal   (ex_illegal)
`ifdef ISSUE_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_bubble  (perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode written from the instruction-set tables.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
        exp_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        e.a = '0; e.b = '0; e.op = '0; e.rd = '0; e.rw = 1'b0; e.br = 1'b0; e.ill = 1'b1;
        if (opc == 7'h33) begin
            if (f3 == 3'd0 && f7 == 7'h00) begin e.op = 4'b0010; e.ill = 1'b0; end
            if (f3 == 3'd0 && f7 == 7'h20) begin e.op = 4'b0110; e.ill = 1'b0; end
            if (f3 == 3'd7 && f7 == 7'h00) begin e.op = 4'b0000; e.ill = 1'b0; end
            if (f3 == 3'd6 && f7 == 7'h00) begin e.op = 4'b0001; e.ill = 1'b0; end
            if (f3 == 3'd4 && f7 == 7'h20) begin e.op = 4'b1100; e.ill = 1'b0; end
            if (!e.ill) begin e.a = r1; e.b = r2; e.rw = 1'b1; e.rd = ins[11:7]; end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd0) begin
                e.op = 4'b1001; e.ill = 1'b0; e.b = {{52{ins[31]}}, ins[31:20]};
            end else if (f3 == 3'd1 && ins[31:26] == 6'd0) begin
                e.op = 4'b1111; e.ill = 1'b0; e.b = {58'd0, ins[25:20]};
            end
            if (!e.ill) begin e.a = r1; e.rw = 1'b1; e.rd = ins[11:7]; end
        end else if (opc == 7'h63) begin
            if (f3 == 3'd4) begin e.op = 4'b1000; e.ill = 1'b0; end
            if (f3 == 3'd0) begin e.op = 4'b0110; e.ill = 1'b0; end
            if (!e.ill) begin e.a = r1; e.b = r2; e.br = 1'b1; end
        end else if (opc == 7'h03 && f3 == 3'd3) begin
            e.ill = 1'b0; e.op = 4'b0010; e.a = r1; e.b = {{52{ins[31]}}, ins[31:20]};
            e.rw = 1'b1; e.rd = ins[11:7];
        end else if (opc == 7'h23 && f3 == 3'd3) begin
            e.ill = 1'b0; e.op = 4'b0010; e.a = r1;
            e.b = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        end
        return e;
    endfunction

    // Output monitor: scoreboard pop on transfer, push on accept, hold-stability check.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_prev) begin
                chk("stall_stable_a", ex_a, snap.a);
                chk("stall_stable_b", ex_b, snap.b);
                chk("stall_stable_ctl", 64'({ex_alu_op, ex_rd, ex_reg_write, ex_branch, ex_illegal}),
                    64'({snap.op, snap.rd, snap.rw, snap.br, snap.ill}));
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (ex_valid && ex_ready) begin
                    n_xfer++;
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'(ex_valid), 64'(1'b0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_a", ex_a, e.a);
                        chk("sb_b", ex_b, e.b);
                        chk("sb_op", 64'(ex_alu_op), 64'(e.op));
                        chk("sb_rd", 64'(ex_rd), 64'(e.rd));
                        chk("sb_flags", 64'({ex_reg_write, ex_branch, ex_illegal}), 64'({e.rw, e.br, e.ill}));
                    end
                end
                if (in_valid && in_ready) sb.push_back(model(instr, rs1_data, rs2_data));
            end
            if (ex_ready && !ex_valid) n_bubble++;
            stall_prev = ex_valid && !ex_ready && !flush;
            snap.a = ex_a; snap.b = ex_b; snap.op = ex_alu_op; snap.rd = ex_rd;
            snap.rw = ex_reg_write; snap.br = ex_branch; snap.ill = ex_illegal;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2, input bit rnd_ready);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            if (rnd_ready) ex_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 64'(in_ready), 64'(1'b1));
        @(posedge clk); #1;
        if (rnd_ready) ex_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g        = 0;
        ex_ready = 1'b1;
        while (sb.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mix [12];
        reset_n  = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        rs1_data = '0;
        rs2_data = '0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        mix = '{32'hFF81B183, 32'hFE20BE23, 32'h4020C1B3, 32'h0020E1B3,
                32'h0020F1B3, 32'h00208463, 32'h04109093, 32'h022081B3,
                32'h00508093, 32'h0081A183, 32'h407302B3, 32'h0020C463};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 64'(ex_valid), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_ex_a", ex_a, 64'd0);
        chk("rst_ex_b", ex_b, 64'd0);
        chk("rst_ctl", 64'({ex_alu_op, ex_rd, ex_reg_write, ex_branch, ex_illegal}), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ADD x3,x1,x2
        ex_ready = 1'b1;
        send(32'h002081B3, 64'd5, 64'd7, 1'b0);
        idle();
        @(negedge clk);
        chk("add_valid", 64'(ex_valid), 64'(1'b1));
        chk("add_op", 64'(ex_alu_op), 64'(4'b0010));
        chk("add_a", ex_a, 64'd5);
        chk("add_b", ex_b, 64'd7);
        chk("add_rd", 64'(ex_rd), 64'(5'd3));
        chk("add_rw", 64'(ex_reg_write), 64'(1'b1));

        // ADDI x1,x1,-1
        send(32'hFFF08093, 64'd10, 64'd99, 1'b0);
        idle();
        @(negedge clk);
        chk("addi_op", 64'(ex_alu_op), 64'(4'b1001));
        chk("addi_a", ex_a, 64'd10);
        chk("addi_b", ex_b, 64'hFFFF_FFFF_FFFF_FFFF);

        // SLLI x1,x1,63 then BLT x1,x2
        send(32'h03F09093, 64'd1, 64'd2, 1'b0);
        idle();
        @(negedge clk);
        chk("slli_op", 64'(ex_alu_op), 64'(4'b1111));
        chk("slli_b", ex_b, 64'd63);
        send(32'h0020C463, 64'd3, 64'd9, 1'b0);
        idle();
        @(negedge clk);
        chk("blt_op", 64'(ex_alu_op), 64'(4'b1000));
        chk("blt_br_rw_rd", 64'({ex_branch, ex_reg_write, ex_rd}), 64'({1'b1, 1'b0, 5'd0}));
        chk("blt_b", ex_b, 64'd9);

        // Back-to-back issue under backpressure: second bundle goes to skid
        @(posedge clk); #1;
        ex_ready = 1'b0;
        send(32'h002081B3, 64'h111, 64'h1, 1'b0);
        send(32'h407302B3, 64'h222, 64'h2, 1'b0);
        instr = 32'h0020F1B3;
        rs1_data = 64'h333;
        @(negedge clk);
        chk("skid_in_ready", 64'(in_ready), 64'(1'b0));
        chk("skid_head_a", ex_a, 64'h111);
        repeat (2) begin
            @(negedge clk);
            chk("skid_hold_ready", 64'(in_ready), 64'(1'b0));
        end
        @(posedge clk); #1;
        idle();
        drain();
        @(posedge clk); #1;
        chk("post_drain_ready", 64'(in_ready), 64'(1'b1));

        // Flush in SKID with input offered
        ex_ready = 1'b0;
        send(32'h0020E1B3, 64'h444, 64'h4, 1'b0);
        send(32'h4020C1B3, 64'h555, 64'h5, 1'b0);
        instr    = 32'h00508093;
        rs1_data = 64'h666;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_skid_valid", 64'(ex_valid), 64'(1'b0));
        chk("flush_skid_ready", 64'(in_ready), 64'(1'b1));
        ex_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_skid_quiet", 64'(ex_valid), 64'(1'b0));
        end

        // Flush in FULL beats an accepted input
        @(posedge clk); #1;
        ex_ready = 1'b0;
        send(32'h002081B3, 64'h777, 64'h7, 1'b0);
        instr = 32'h0020F1B3;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_full_valid", 64'(ex_valid), 64'(1'b0));
        chk("flush_full_ready", 64'(in_ready), 64'(1'b1));

        // Unsupported encoding still flows
        @(posedge clk); #1;
        ex_ready = 1'b1;
        send(32'hFFFFFFFF, 64'h123, 64'h456, 1'b0);
        idle();
        @(negedge clk);
        chk("illegal_valid", 64'(ex_valid), 64'(1'b1));
        chk("illegal_flag", 64'(ex_illegal), 64'(1'b1));
        chk("illegal_op_rw", 64'({ex_alu_op, ex_reg_write}), 64'(0));
        chk("illegal_a", ex_a, 64'd0);

        // Mixed stream with random backpressure
        @(posedge clk); #1;
        foreach (mix[i]) send(mix[i], {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        idle();
        drain();

`ifdef ISSUE_PERF_EN
        @(posedge clk); #1;
        chk("perf_issued", 64'(perf_issued), 64'(n_xfer));
        chk("perf_bubble", 64'(perf_bubble), 64'(n_bubble));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
